rr_grant_idx32: RTL and testbench
=================================

Name: rr_grant_idx32

Overview:
- Round-robin arbiter over 32 level-sensitive request lines.
- Produces a registered grant index plus valid, held stable under a valid/ready handshake.
- Sits directly upstream of decoder5_32: out_valid drives the decoder's en and out_idx drives its A, so the decoder's Y becomes a one-hot grant vector.
- Pointer-based fairness: each accepted grant moves priority to the next requester after the winner.

Parameters:
- N, 32, number of requesters; fixed at 32 to match the 5-to-32 decoder.
- IDX_W, 5, index width, equal to log2(N).
- CNT_W, 16, width of the accepted-grant counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N  request vector; bit i high = requester i wants a grant.
- out_ready  input  1  consumer accepts the current grant this cycle.
- out_valid  output  1  grant present; connects to decoder en.
- out_idx  output  IDX_W  granted requester index; connects to decoder A.
- grant_cnt  output  CNT_W  count of accepted grants, wrapping.

Behaviour:
- Reset: one clock, synchronous active-low reset (clk, rst_n).
  - Sampled low at an edge: out_valid=0, out_idx=0, ptr=0, grant_cnt=0, state=IDLE.
  - Reset overrides everything, including a pending handshake: the grant is dropped and not counted.
- Selection function pick(req, ptr):
  - Scan indices ptr, ptr+1, …, 31, 0, …, ptr-1 (mod 32).
  - The first set bit wins. found = |req.
- States: IDLE and GRANT.
  - IDLE: out_valid=0.
    - If found, register out_idx=pick(req, ptr) and out_valid=1; next state is GRANT.
    - Latency from req sampled to out_valid is 1 cycle.
  - GRANT: out_valid=1, and out_idx is frozen until acceptance.
    - Changes on req are ignored while in GRANT, including deassertion of the granted bit. The grant stays valid until accepted.
  - Accept occurs at an edge with out_valid=1 and out_ready=1:
    - ptr <= out_idx+1 mod 32 (idx 31 wraps to 0).
    - grant_cnt <= grant_cnt+1 mod 2^CNT_W (0xFFFF wraps to 0x0000).
    - Back-to-back grants are allowed with no bubble:
      - If found on pick(req, out_idx+1) in the same cycle, load the new out_idx and stay in GRANT.
      - Otherwise out_valid <= 0 and go to IDLE.
  - out_ready while out_valid=0 has no effect.
- Only requester pending: repeatedly wins, since the scan wraps back to it. Back-to-back grants of the same index are legal.
- req = all zeros: stays in IDLE; out_idx holds its last value (don't-care for the decoder since en=0).
- All outputs are registered; no combinational path from req or out_ready to any output.
- Fairness guarantee: with all 32 requests held high and out_ready=1, the grant sequence is ptr, ptr+1, …, i.e. every index is granted once per 32 accepts.

Decomposition:
- Package rr_grant_pkg holds:
  - constants N=32, IDX_W=5, CNT_W=16;
  - state typedef {IDLE, GRANT};
  - a helper function for modulo-32 increment.
- One combinational sub-module rr_pick:
  - inputs req[N-1:0] and ptr[IDX_W-1:0]; outputs found and idx[IDX_W-1:0];
  - implemented as a rotate, fixed-priority encode, then add ptr back mod 32.
- Top level holds the FSM, ptr register, output registers and counter.

Test Plan:
- Reset/idle: assert rst_n=0 for 2 cycles with req=32'hFFFF_FFFF → out_valid=0, out_idx=0, grant_cnt=0. Release with req=0 → out_valid stays 0.
- Single request, 1-cycle latency: req=32'h0010_0000 (bit 20), out_ready=0 → next cycle out_valid=1, out_idx=5'b10100. Decoder Y=32'h0010_0000.
- Hold under backpressure: keep out_ready=0 for 4 cycles, then change req to bit 16 → out_idx stays 20. Assert out_ready → next grant out_idx=16, grant_cnt=1.
- Rotation and wrap: req=32'hFFFF_FFFF, out_ready=1 from reset → 33 consecutive cycles show out_idx 0,1,…,31,0; grant_cnt=33 at end.
- Pointer fairness: ptr=11 after granting 10, then req has bits 10 and 3 set → grant 10 is skipped in favour of the scan from 11. Sequence is 3, then 10, then 3.
- Mid-operation reset and counter wrap:
  - Preload grant_cnt to 0xFFFF via 65535 accepts (or force), accept once → grant_cnt=0x0000.
  - Pull rst_n low while out_valid=1 → next edge out_valid=0, ptr=0, and the grant is not counted.

Source files
------------

// File: rtl/rr_grant_pkg.sv
// Shared constants, FSM state type and index helper for the round-robin grant block.
package rr_grant_pkg;

    localparam int N     = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Next index after idx; 31 wraps to 0 through the natural 5-bit overflow.
    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_grant_idx32_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 32.
module rr_pick
    import rr_grant_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;

    // Rotate so that requester ptr lands on bit 0 of rot.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N-1:0];

    // Fixed-priority encode of the rotated vector (lowest bit wins), then undo the rotation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        found = |req;
        idx   = ptr + off;
    end

endmodule

// File: rtl/rr_grant_idx32.sv
// Round-robin arbiter over 32 requesters with a registered index/valid grant
// held under a valid/ready handshake; feeds a 5-to-32 decoder (en, A).
module rr_grant_idx32
    import rr_grant_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] grant_cnt
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] scan_base;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    // In GRANT the only pick that matters is the back-to-back one, which
    // scans from just past the current winner; in IDLE it scans from ptr.
    always_comb begin
        scan_base = ptr;
        if (state == GRANT) scan_base = inc_idx(out_idx);
    end

    rr_pick u_pick (
        .req   (req),
        .ptr   (scan_base),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant FSM with pointer, registered outputs and accepted-grant counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= '0;
            grant_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        out_idx   <= pick_idx;
                        out_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // req changes are ignored here; only acceptance releases the grant.
                    if (out_ready) begin
                        ptr       <= inc_idx(out_idx);
                        grant_cnt <= grant_cnt + CNT_W'(1);
                        if (pick_found) begin
                            out_idx <= pick_idx;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_idx32.sv
// Directed self-checking bench for rr_grant_idx32 with hand-computed expectations.
module tb_rr_grant_idx32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic [15:0] grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_grant_idx32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .grant_cnt (grant_cnt)
    );

    // Downstream decoder5_32 model: one-hot of out_idx when enabled.
    function automatic logic [31:0] dec_y(input logic en, input logic [4:0] a);
        return en ? (32'h1 << a) : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every request high: nothing may be granted.
        rst_n     = 1'b0;
        req       = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx",   32'(out_idx),   32'd0);
        check("rst_cnt",   32'(grant_cnt), 32'd0);

        rst_n = 1'b1;
        req   = 32'h0;
        tick();
        check("idle_nreq_valid0", 32'(out_valid), 32'd0);
        tick();
        check("idle_nreq_valid1", 32'(out_valid), 32'd0);

        // Single request at bit 20, one-cycle latency.
        req = 32'h0010_0000;
        tick();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_idx",   32'(out_idx),   32'd20);
        check("single_dec_y", dec_y(out_valid, out_idx), 32'h0010_0000);
        check("single_cnt",   32'(grant_cnt), 32'd0);

        // Backpressure: grant frozen, then req change ignored.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_idx", 32'(out_idx), 32'd20);
        end
        req = 32'h0001_0000;
        tick();
        check("hold_reqchg_idx",   32'(out_idx),   32'd20);
        check("hold_reqchg_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("b2b_idx",   32'(out_idx),   32'd16);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_cnt",   32'(grant_cnt), 32'd1);
        req = 32'h0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_cnt",   32'(grant_cnt), 32'd2);

        // Rotation and wrap from reset with all requests and ready high.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req       = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            tick();
            check("rot_idx",   32'(out_idx),   32'(k % 32));
            check("rot_valid", 32'(out_valid), 32'd1);
        end
        check("rot_cnt32", 32'(grant_cnt), 32'd32);
        tick();
        check("rot_cnt33", 32'(grant_cnt), 32'd33);

        // Pointer fairness: after granting 10 the scan starts at 11.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req       = 32'h0000_0400;
        out_ready = 1'b0;
        tick();
        check("fair_first", 32'(out_idx), 32'd10);
        req       = 32'h0000_0408;
        out_ready = 1'b1;
        tick();
        check("fair_seq0", 32'(out_idx), 32'd3);
        tick();
        check("fair_seq1", 32'(out_idx), 32'd10);
        tick();
        check("fair_seq2", 32'(out_idx), 32'd3);
        check("fair_cnt",  32'(grant_cnt), 32'd3);

        // Counter wrap: 65532 more accepts reach 0xFFFF, one more wraps to 0.
        req = 32'hFFFF_FFFF;
        repeat (65532) tick();
        check("wrap_ffff",  32'(grant_cnt), 32'h0000_FFFF);
        check("wrap_valid", 32'(out_valid), 32'd1);
        tick();
        check("wrap_zero", 32'(grant_cnt), 32'd0);

        // Reset during a pending handshake: grant dropped and not counted.
        check("midrst_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_cnt",   32'(grant_cnt), 32'd0);
        check("midrst_idx",   32'(out_idx),   32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        req       = 32'hFFFF_FFFF;
        tick();
        check("midrst_ptr0_idx",   32'(out_idx),   32'd0);
        check("midrst_ptr0_valid", 32'(out_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
